// File: rtl/rv32i_types_pkg.sv
// Shared RV32 pipeline types.
// Queue entry layout is common to decode, queue and execute.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  vsetvl;
  } queue_entry_t;

endpackage

// File: rtl/stage4_inst_queue.sv
// Decode-to-execute instruction queue.
// Circular buffer in flops; head is read combinationally.
module stage4_inst_queue
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     queue_wen,
  input  word_t                    pc_decode,
  input  word_t                    instr_decode,
  input  logic                     vsetvl_decode,
  input  logic                     ex_ready,
  input  logic                     stall_queue,
  input  logic                     flush_queue,
  output logic                     valid_q,
  output word_t                    pc_q,
  output word_t                    instr_q,
  output logic                     vsetvl_q,
  output logic                     is_queue_full,
  output logic                     is_queue_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  queue_entry_t       mem [DEPTH];
  queue_entry_t       head;
  queue_entry_t       wr_entry;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               pop;
  logic               push;
  logic               drop;

  assign is_queue_full  = (count == CW'(DEPTH));
  assign is_queue_empty = (count == '0);
  assign valid_q        = ~is_queue_empty;

  assign head     = mem[rd_ptr];
  assign pc_q     = head.pc;
  assign instr_q  = head.instr;
  assign vsetvl_q = head.vsetvl;

  assign pop  = ex_ready & valid_q
              & ~stall_queue & ~flush_queue;
  assign push = queue_wen & ~flush_queue
              & (~is_queue_full | pop);
  assign drop = queue_wen & ~flush_queue & ~push;

  assign wr_entry = '{
    pc:     pc_decode,
    instr:  instr_decode,
    vsetvl: vsetvl_decode
  };

  // Storage is never reset; valid_q masks stale contents.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (flush_queue) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
